rdma_sched_rx_buf: RTL and testbench

Store-and-forward packet buffer at the consumer end of the scheduler's output stream. The scheduler stream carries valid/data/last with no backpressure, so this block absorbs every beat. It commits only complete packets and presents them downstream on a valid/ready interface. A packet that cannot fit is discarded whole and counted; no partial packet is ever emitted.

---
 rtl/rdma_sched_rx_buf.sv | 137 +++++++++++++
 tb/tb_rdma_sched_rx_buf.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rdma_sched_rx_buf.sv
// Store-and-forward receive buffer: absorbs the scheduler stream, commits whole
// packets, drops packets that overflow and emits committed words on valid/ready.
module rdma_sched_rx_buf #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx_valid,
    input  logic [DATA_W-1:0]        rx_data,
    input  logic                     rx_last,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [DATA_W-1:0]        tx_data,
    output logic                     tx_last,
    output logic [$clog2(DEPTH):0]   pkt_cnt,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     drop_pulse
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic {
        ACCEPT,
        DROP
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   wr_commit_q, wr_commit_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic            drop_pulse_q, drop_pulse_d;

    logic [DATA_W:0] mem_q [DEPTH];
    logic [DATA_W:0] head;
    logic            full;
    logic            wr_en;
    logic            pkt_inc;
    logic            pkt_dec;
    logic            rd_fire;

    // Occupancy counts speculative words too, so a partial packet holds space.
    assign full     = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign tx_valid = rd_ptr_q != wr_commit_q;
    assign tx_data  = head[DATA_W-1:0];
    assign tx_last  = head[DATA_W];
    assign rd_fire  = tx_valid && tx_ready;
    assign pkt_dec  = rd_fire && tx_last;

    assign pkt_cnt    = pkt_cnt_q;
    assign drop_cnt   = drop_cnt_q;
    assign drop_pulse = drop_pulse_q;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        wr_commit_d  = wr_commit_q;
        drop_cnt_d   = drop_cnt_q;
        drop_pulse_d = 1'b0;
        wr_en        = 1'b0;
        pkt_inc      = 1'b0;
        if (rx_valid) begin
            unique case (state_q)
                ACCEPT: begin
                    if (!full) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        if (rx_last) begin
                            wr_commit_d = wr_ptr_q + PW'(1);
                            pkt_inc     = 1'b1;
                        end
                    end else begin
                        wr_ptr_d     = wr_commit_q;
                        drop_pulse_d = 1'b1;
                        if (drop_cnt_q != {CNT_W{1'b1}}) begin
                            drop_cnt_d = drop_cnt_q + CNT_W'(1);
                        end
                        if (!rx_last) begin
                            state_d = DROP;
                        end
                    end
                end
                DROP: begin
                    if (rx_last) begin
                        state_d = ACCEPT;
                    end
                end
            endcase
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        pkt_cnt_d = pkt_cnt_q;
        unique case ({pkt_inc, pkt_dec})
            2'b10:   pkt_cnt_d = pkt_cnt_q + PW'(1);
            2'b01:   pkt_cnt_d = pkt_cnt_q - PW'(1);
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ACCEPT;
            wr_ptr_q     <= '0;
            wr_commit_q  <= '0;
            rd_ptr_q     <= '0;
            pkt_cnt_q    <= '0;
            drop_cnt_q   <= '0;
            drop_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            wr_commit_q  <= wr_commit_d;
            rd_ptr_q     <= rd_ptr_d;
            pkt_cnt_q    <= pkt_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            drop_pulse_q <= drop_pulse_d;
        end
    end

    // Storage needs no reset: tx_valid gates every read of it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {rx_last, rx_data};
        end
    end

endmodule

// File: tb/tb_rdma_sched_rx_buf.sv
// Bench for rdma_sched_rx_buf: directed scenarios plus randomized traffic
// checked cycle by cycle against a queue-based packet model.
module tb_rdma_sched_rx_buf;

    localparam int DW    = 64;
    localparam int DEPTH = 64;
    localparam int CNT_W = 16;
    localparam int PW    = $clog2(DEPTH) + 1;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic          clk;
    logic          rst_n;
    logic          rx_valid;
    logic [DW-1:0] rx_data;
    logic          rx_last;
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] tx_data;
    logic          tx_last;
    logic [PW-1:0] pkt_cnt;
    logic [CNT_W-1:0] drop_cnt;
    logic          drop_pulse;

    int checks;
    int failures;
    int pulses;
    logic [DW:0] got_q[$];

    rdma_sched_rx_buf #(
        .DATA_W(DW),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_last   (rx_last),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_last   (tx_last),
        .pkt_cnt   (pkt_cnt),
        .drop_cnt  (drop_cnt),
        .drop_pulse(drop_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packet-level model: committed words, the packet in flight, drop mode.
    logic [DW:0] m_q[$];
    logic [DW:0] m_p[$];
    bit m_drop;
    int m_pkt;
    int m_dcnt;
    bit m_pulse;

    always @(posedge clk or negedge rst_n) begin
        int occ;
        if (!rst_n) begin
            m_q.delete();
            m_p.delete();
            m_drop  = 0;
            m_pkt   = 0;
            m_dcnt  = 0;
            m_pulse = 0;
        end else begin
            occ     = m_q.size() + m_p.size();
            m_pulse = 0;
            if (m_q.size() > 0 && tx_ready) begin
                if (m_q[0][DW]) m_pkt--;
                void'(m_q.pop_front());
            end
            if (rx_valid) begin
                if (m_drop) begin
                    if (rx_last) m_drop = 0;
                end else if (occ == DEPTH) begin
                    m_p.delete();
                    m_pulse = 1;
                    if (m_dcnt < CMAX) m_dcnt++;
                    if (!rx_last) m_drop = 1;
                end else begin
                    m_p.push_back({rx_last, rx_data});
                    if (rx_last) begin
                        foreach (m_p[i]) m_q.push_back(m_p[i]);
                        m_p.delete();
                        m_pkt++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_valid && tx_ready) got_q.push_back({tx_last, tx_data});
            if (drop_pulse) pulses++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic l);
        rx_valid = 1'b1;
        rx_data  = d;
        rx_last  = l;
        tick();
        rx_valid = 1'b0;
        rx_last  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        got_q.delete();
        pulses = 0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_tx_valid got=%0b exp=0", tx_valid);
        end
        checks++;
        if (pkt_cnt !== '0 || drop_cnt !== '0 || drop_pulse !== 1'b0) begin
            failures++;
            $display("FAIL reset_counters got=%0d/%0d/%0b exp=0/0/0",
                     pkt_cnt, drop_cnt, drop_pulse);
        end
    endtask

    task automatic test_single();
        logic [DW:0] e;
        tx_ready = 1'b1;
        beat(64'hA0, 1'b0);
        beat(64'hA1, 1'b0);
        checks++;
        if (tx_valid !== 1'b0 || pkt_cnt !== 0) begin
            failures++;
            $display("FAIL single_early got=%0b/%0d exp=0/0", tx_valid, pkt_cnt);
        end
        beat(64'hA2, 1'b1);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 64'hA0 || tx_last !== 1'b0) begin
            failures++;
            $display("FAIL single_commit got=%0b/%0h/%0b exp=1/a0/0",
                     tx_valid, tx_data, tx_last);
        end
        checks++;
        if (pkt_cnt !== 1) begin
            failures++;
            $display("FAIL single_pkt1 got=%0d exp=1", pkt_cnt);
        end
        repeat (5) tick();
        checks++;
        if (got_q.size() != 3) begin
            failures++;
            $display("FAIL single_count got=%0d exp=3", got_q.size());
        end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            e = {(i == 2), 64'hA0 + 64'(i)};
            checks++;
            if (got_q[i] !== e) begin
                failures++;
                $display("FAIL single_word%0d got=%0h exp=%0h", i, got_q[i], e);
            end
        end
        checks++;
        if (pkt_cnt !== 0 || tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_drain got=%0d/%0b exp=0/0", pkt_cnt, tx_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW:0] e;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            beat(64'h10 + 64'(2 * p), 1'b0);
            beat(64'h11 + 64'(2 * p), 1'b1);
        end
        tick();
        checks++;
        if (pkt_cnt !== 4 || tx_valid !== 1'b1 || tx_data !== 64'h10) begin
            failures++;
            $display("FAIL b2b_stalled got=%0d/%0b/%0h exp=4/1/10",
                     pkt_cnt, tx_valid, tx_data);
        end
        tx_ready = 1'b1;
        repeat (12) tick();
        checks++;
        if (got_q.size() != 8) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=8", got_q.size());
        end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            e = {(i % 2 == 1), 64'h10 + 64'(i)};
            checks++;
            if (got_q[i] !== e) begin
                failures++;
                $display("FAIL b2b_word%0d got=%0h exp=%0h", i, got_q[i], e);
            end
        end
        checks++;
        if (pkt_cnt !== 0) begin
            failures++;
            $display("FAIL b2b_pkt_end got=%0d exp=0", pkt_cnt);
        end
    endtask

    task automatic test_exact_fit();
        logic [DW:0] e;
        int bad;
        do_reset();
        for (int i = 0; i < DEPTH; i++) beat(64'h200 + 64'(i), i == DEPTH - 1);
        checks++;
        if (pkt_cnt !== 1 || tx_valid !== 1'b1 || drop_cnt !== 0) begin
            failures++;
            $display("FAIL exact_commit got=%0d/%0b/%0d exp=1/1/0",
                     pkt_cnt, tx_valid, drop_cnt);
        end
        tx_ready = 1'b1;
        repeat (DEPTH + 6) tick();
        checks++;
        if (got_q.size() != DEPTH) begin
            failures++;
            $display("FAIL exact_count got=%0d exp=%0d", got_q.size(), DEPTH);
        end
        bad = 0;
        for (int i = 0; i < DEPTH && i < got_q.size(); i++) begin
            e = {(i == DEPTH - 1), 64'h200 + 64'(i)};
            if (got_q[i] !== e) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL exact_words got=%0d_bad exp=0_bad", bad);
        end
        checks++;
        if (drop_cnt !== 0 || pulses != 0) begin
            failures++;
            $display("FAIL exact_nodrop got=%0d/%0d exp=0/0", drop_cnt, pulses);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i <= DEPTH; i++) beat(64'h300 + 64'(i), i == DEPTH);
        checks++;
        if (drop_pulse !== 1'b1 || drop_cnt !== 1) begin
            failures++;
            $display("FAIL ovf_pulse got=%0b/%0d exp=1/1", drop_pulse, drop_cnt);
        end
        checks++;
        if (tx_valid !== 1'b0 || pkt_cnt !== 0) begin
            failures++;
            $display("FAIL ovf_empty got=%0b/%0d exp=0/0", tx_valid, pkt_cnt);
        end
        beat(64'hB0, 1'b0);
        checks++;
        if (drop_pulse !== 1'b0) begin
            failures++;
            $display("FAIL ovf_pulse_len got=%0b exp=0", drop_pulse);
        end
        beat(64'hB1, 1'b1);
        tx_ready = 1'b1;
        repeat (5) tick();
        checks++;
        if (got_q.size() != 2 || got_q[0] !== {1'b0, 64'hB0}
            || got_q[1] !== {1'b1, 64'hB1}) begin
            failures++;
            $display("FAIL ovf_output got=%0d_words exp=2_words_b0_b1", got_q.size());
        end
        checks++;
        if (pulses != 1 || drop_cnt !== 1) begin
            failures++;
            $display("FAIL ovf_totals got=%0d/%0d exp=1/1", pulses, drop_cnt);
        end
    endtask

    task automatic test_drop_keep();
        logic [DW:0] e;
        int bad;
        do_reset();
        for (int i = 0; i < 60; i++) beat(64'h400 + 64'(i), i == 59);
        for (int i = 0; i < 8; i++) beat(64'h500 + 64'(i), i == 7);
        checks++;
        if (drop_cnt !== 1 || pkt_cnt !== 1 || pulses != 1) begin
            failures++;
            $display("FAIL keep_drop got=%0d/%0d/%0d exp=1/1/1",
                     drop_cnt, pkt_cnt, pulses);
        end
        tx_ready = 1'b1;
        repeat (70) tick();
        checks++;
        if (got_q.size() != 60) begin
            failures++;
            $display("FAIL keep_count got=%0d exp=60", got_q.size());
        end
        bad = 0;
        for (int i = 0; i < 60 && i < got_q.size(); i++) begin
            e = {(i == 59), 64'h400 + 64'(i)};
            if (got_q[i] !== e) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL keep_words got=%0d_bad exp=0_bad", bad);
        end
    endtask

    task automatic test_reset_mid();
        tx_ready = 1'b0;
        beat(64'hD0, 1'b0);
        beat(64'hD1, 1'b0);
        do_reset();
        checks++;
        if (pkt_cnt !== 0 || drop_cnt !== 0 || tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_counters got=%0d/%0d/%0b exp=0/0/0",
                     pkt_cnt, drop_cnt, tx_valid);
        end
        tx_ready = 1'b1;
        beat(64'hC0, 1'b1);
        repeat (4) tick();
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {1'b1, 64'hC0}) begin
            failures++;
            $display("FAIL rstmid_output got=%0d_words exp=1_word_c0_last",
                     got_q.size());
        end
    endtask

    task automatic test_random();
        int rem;
        do_reset();
        rem = 0;
        for (int c = 0; c < 3000; c++) begin
            if ((c / 150) % 3 == 0) tx_ready = ($urandom_range(0, 9) == 0);
            else tx_ready = ($urandom_range(0, 3) != 0);
            rx_data = {$urandom, $urandom};
            if ($urandom_range(0, 4) != 0) begin
                if (rem == 0) rem = $urandom_range(1, 24);
                rx_valid = 1'b1;
                rx_last  = (rem == 1);
                rem--;
            end else begin
                rx_valid = 1'b0;
                rx_last  = 1'($urandom_range(0, 1));
            end
            tick();
            checks++;
            if (tx_valid !== (m_q.size() > 0)) begin
                failures++;
                $display("FAIL rnd_valid c=%0d got=%0b exp=%0b",
                         c, tx_valid, m_q.size() > 0);
            end else if (tx_valid && {tx_last, tx_data} !== m_q[0]) begin
                failures++;
                $display("FAIL rnd_head c=%0d got=%0h exp=%0h",
                         c, {tx_last, tx_data}, m_q[0]);
            end
            checks++;
            if (pkt_cnt !== PW'(m_pkt) || drop_cnt !== CNT_W'(m_dcnt)) begin
                failures++;
                $display("FAIL rnd_counts c=%0d got=%0d/%0d exp=%0d/%0d",
                         c, pkt_cnt, drop_cnt, m_pkt, m_dcnt);
            end
            checks++;
            if (drop_pulse !== m_pulse) begin
                failures++;
                $display("FAIL rnd_pulse c=%0d got=%0b exp=%0b", c, drop_pulse, m_pulse);
            end
        end
        rx_valid = 1'b0;
        rx_last  = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        pulses   = 0;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        rx_last  = 1'b0;
        tx_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_exact_fit();
        test_overflow();
        test_drop_keep();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
